// File: rtl/fp_add_sub_pipe.sv
// Four-stage pipelined floating-point adder/subtractor: unpack/swap, align,
// add/sub, normalise/round. Denormals flush to zero; rounding is nearest-even.
module fp_add_sub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] dataa,
  input  logic [EXP_W+MAN_W:0] datab,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int AW = MAN_W + 5;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0] DSAT = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EONE = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             spec;
    logic [W-1:0]     specRes;
    logic [3:0]       specFlags;
    logic             sX;
    logic [EXP_W-1:0] eX;
  } ctl_t;

  ctl_t             w_c0, r_c1, r_c2, r_c3;
  logic             r_sub1, r_sub2, r_v4;
  logic [EXP_W-1:0] r_diff1;
  logic [MAN_W:0]   r_sigX1, r_sigY1, r_sigX2;
  logic [SW-1:0]    r_yAl2;
  logic [AW-1:0]    r_sum3;
  logic [W-1:0]     r_result;
  logic [TAG_W-1:0] r_tag4;
  logic [3:0]       r_flags4;

  logic             w_en, w_sa, w_sb, w_swap;
  logic             w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB;
  logic [W-2:0]     w_keyA, w_keyB, w_keyX, w_keyY;
  logic [EXP_W-1:0] w_dsat;
  logic [SW-1:0]    w_yExt, w_yShift, w_mask, w_yAl, w_norm;
  logic [AW-1:0]    w_sum;
  logic [EW-1:0]    w_pos, w_lz;
  logic signed [EW-1:0] w_eX, w_eN, w_eR;
  logic [MAN_W:0]   w_frac;
  logic             w_carry, w_rup, w_inex;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flags;

  // The whole pipe advances together; a stalled output freezes every stage, bubbles included.
  assign w_en      = !r_v4 || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_v4;
  assign result    = r_result;
  assign out_tag   = r_tag4;
  assign out_flags = r_flags4;

  assign w_sa    = dataa[W-1];
  assign w_sb    = datab[W-1] ^ op;
  assign w_zeroA = (dataa[W-2:MAN_W] == '0);
  assign w_zeroB = (datab[W-2:MAN_W] == '0);
  assign w_infA  = (dataa[W-2:MAN_W] == '1) && (dataa[MAN_W-1:0] == '0);
  assign w_infB  = (datab[W-2:MAN_W] == '1) && (datab[MAN_W-1:0] == '0);
  assign w_nanA  = (dataa[W-2:MAN_W] == '1) && (dataa[MAN_W-1:0] != '0);
  assign w_nanB  = (datab[W-2:MAN_W] == '1) && (datab[MAN_W-1:0] != '0);
  assign w_keyA  = w_zeroA ? '0 : dataa[W-2:0];
  assign w_keyB  = w_zeroB ? '0 : datab[W-2:0];
  assign w_swap  = w_keyB > w_keyA;
  assign w_keyX  = w_swap ? w_keyB : w_keyA;
  assign w_keyY  = w_swap ? w_keyA : w_keyB;

  always_comb begin
    w_c0       = '0;
    w_c0.valid = in_valid;
    w_c0.tag   = in_tag;
    w_c0.sX    = w_swap ? w_sb : w_sa;
    w_c0.eX    = w_keyX[W-2:MAN_W];
    if (w_nanA || w_nanB) begin
      w_c0.spec    = 1'b1;
      w_c0.specRes = QNAN;
    end else if (w_infA && w_infB && (w_sa != w_sb)) begin
      w_c0.spec      = 1'b1;
      w_c0.specRes   = QNAN;
      w_c0.specFlags = 4'b1000;
    end else if (w_infA) begin
      w_c0.spec    = 1'b1;
      w_c0.specRes = {w_sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_infB) begin
      w_c0.spec    = 1'b1;
      w_c0.specRes = {w_sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_zeroA && w_zeroB) begin
      w_c0.spec    = 1'b1;
      w_c0.specRes = {w_sa & w_sb, {(W-1){1'b0}}};
    end
  end

  // Alignment keeps guard/round bits and folds everything shifted further into sticky.
  assign w_dsat   = (r_diff1 > DSAT) ? DSAT : r_diff1;
  assign w_yExt   = {r_sigY1, 3'b000};
  assign w_yShift = w_yExt >> w_dsat;
  assign w_mask   = (SW'(1) << w_dsat) - SW'(1);
  assign w_yAl    = {w_yShift[SW-1:1], w_yShift[0] | (|(w_yExt & w_mask))};

  assign w_sum = r_sub2 ? ({1'b0, r_sigX2, 3'b000} - {1'b0, r_yAl2})
                        : ({1'b0, r_sigX2, 3'b000} + {1'b0, r_yAl2});

  always_comb begin
    w_pos = '0;
    for (int i = 0; i < AW; i++) begin
      if (r_sum3[i]) w_pos = EW'(i);
    end
  end

  assign w_carry = r_sum3[AW-1];
  assign w_lz    = EW'(AW - 2) - w_pos;
  assign w_eX    = $signed({2'b00, r_c3.eX});
  assign w_eN    = w_carry ? w_eX + EONE : w_eX - $signed(w_lz);
  assign w_norm  = w_carry ? {r_sum3[AW-1:2], |r_sum3[1:0]} : (r_sum3[SW-1:0] << w_lz);
  assign w_rup   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_inex  = |w_norm[2:0];
  // A carry out of the fraction means rounding rolled the significand over to the next binade.
  assign w_frac  = {1'b0, w_norm[SW-2:3]} + {{MAN_W{1'b0}}, w_rup};
  assign w_eR    = w_frac[MAN_W] ? w_eN + EONE : w_eN;

  always_comb begin
    w_res   = {r_c3.sX, w_eR[EXP_W-1:0], w_frac[MAN_W-1:0]};
    w_flags = {3'b000, w_inex};
    if (r_c3.spec) begin
      w_res   = r_c3.specRes;
      w_flags = r_c3.specFlags;
    end else if (!w_norm[SW-1]) begin
      w_res   = '0;
      w_flags = '0;
    end else if (w_eN < EONE) begin
      w_res   = {r_c3.sX, {(W-1){1'b0}}};
      w_flags = 4'b0011;
    end else if (w_eR >= EMAX) begin
      w_res   = {r_c3.sX, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c1     <= '0;
      r_c2     <= '0;
      r_c3     <= '0;
      r_sub1   <= 1'b0;
      r_sub2   <= 1'b0;
      r_diff1  <= '0;
      r_sigX1  <= '0;
      r_sigY1  <= '0;
      r_sigX2  <= '0;
      r_yAl2   <= '0;
      r_sum3   <= '0;
      r_v4     <= 1'b0;
      r_result <= '0;
      r_tag4   <= '0;
      r_flags4 <= '0;
    end else if (w_en) begin
      r_c1     <= w_c0;
      r_sub1   <= w_sa ^ w_sb;
      r_diff1  <= w_keyX[W-2:MAN_W] - w_keyY[W-2:MAN_W];
      r_sigX1  <= {|w_keyX[W-2:MAN_W], w_keyX[MAN_W-1:0]};
      r_sigY1  <= {|w_keyY[W-2:MAN_W], w_keyY[MAN_W-1:0]};
      r_c2     <= r_c1;
      r_sub2   <= r_sub1;
      r_sigX2  <= r_sigX1;
      r_yAl2   <= w_yAl;
      r_c3     <= r_c2;
      r_sum3   <= w_sum;
      r_v4     <= r_c3.valid;
      r_result <= w_res;
      r_tag4   <= r_c3.tag;
      r_flags4 <= w_flags;
    end
  end
endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Self-checking bench for fp_add_sub_pipe: exact-arithmetic reference model,
// FIFO scoreboard, directed vectors, stall and mid-stream reset scenarios.
module tb_fp_add_sub_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int TAG_W = 4;
  localparam int W     = 32;

  typedef struct packed {
    logic        o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             op = 1'b0;
  logic [W-1:0]     dataa = '0;
  logic [W-1:0]     datab = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  int               nChecks = 0;
  int               nFails = 0;
  logic [35:0]      expQ[$];
  logic [TAG_W-1:0] tagQ[$];
  vec_t             vecs[18];

  always #5 clk = ~clk;

  fp_add_sub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dataa(dataa), .datab(datab), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .out_flags(out_flags)
  );

  // Reference: operands become exact integers in units of 2^-149, summed exactly, then rounded.
  function automatic logic [35:0] refModel(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, sr, nanA, nanB, infA, infB, zA, zB, inex, up;
    int ea, eb, p, e, sh;
    logic [319:0] magA, magB, mag, q, rem, half;
    sa = a[31];
    sb = b[31] ^ o;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nanA = (ea == 255) && (a[22:0] != 23'h0);
    nanB = (eb == 255) && (b[22:0] != 23'h0);
    infA = (ea == 255) && (a[22:0] == 23'h0);
    infB = (eb == 255) && (b[22:0] == 23'h0);
    zA = (ea == 0);
    zB = (eb == 0);
    if (nanA || nanB) return {4'b0000, 32'h7FC00000};
    if (infA && infB && (sa != sb)) return {4'b1000, 32'h7FC00000};
    if (infA) return {4'b0000, sa, 8'hFF, 23'h0};
    if (infB) return {4'b0000, sb, 8'hFF, 23'h0};
    if (zA && zB) return {4'b0000, sa & sb, 31'h0};
    magA = zA ? '0 : ({296'h0, 1'b1, a[22:0]} << (ea - 1));
    magB = zB ? '0 : ({296'h0, 1'b1, b[22:0]} << (eb - 1));
    if (sa == sb) begin
      mag = magA + magB;
      sr = sa;
    end else if (magA >= magB) begin
      mag = magA - magB;
      sr = sa;
    end else begin
      mag = magB - magA;
      sr = sb;
    end
    if (mag == '0) return {4'b0000, 32'h0};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e < 1) return {4'b0011, sr, 31'h0};
    sh = p - 23;
    q = mag >> sh;
    inex = 1'b0;
    up = 1'b0;
    if (sh > 0) begin
      rem = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      inex = (rem != '0);
      up = (rem > half) || ((rem == half) && q[0]);
    end
    q = q + {319'd0, up};
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, sr, 8'hFF, 23'h0};
    return {3'b000, inex, sr, e[7:0], q[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input logic o, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] t);
    logic acc;
    int g;
    acc = 1'b0;
    g = 0;
    op = o;
    dataa = a;
    datab = b;
    in_tag = t;
    in_valid = 1'b1;
    while (!acc && g < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL accept timeout: in_ready stayed 0, required 1");
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (expQ.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    checkOutput("drain pending", 64'(expQ.size()), 64'd0);
  endtask

  // Scoreboard: outputs and handshakes are sampled on the falling edge, between drive and capture.
  always @(negedge clk) begin
    logic [35:0] exp;
    logic [TAG_W-1:0] tg;
    if (reset) begin
      expQ.delete();
      tagQ.delete();
    end else begin
      checkOutput("in_ready rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected result: got %h tag %h, required no output", result, out_tag);
        end else begin
          exp = expQ.pop_front();
          tg = tagQ.pop_front();
          checkOutput("result", 64'(result), 64'(exp[31:0]));
          checkOutput("flags", 64'(out_flags), 64'(exp[35:32]));
          checkOutput("tag", 64'(out_tag), 64'(tg));
        end
      end
      if (in_valid && in_ready) begin
        expQ.push_back(refModel(op, dataa, datab));
        tagQ.push_back(in_tag);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000};
    vecs[2]  = '{1'b0, 32'h40400000, 32'hBF800000, 32'h40000000, 4'b0000};
    vecs[3]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[4]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
    vecs[6]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
    vecs[7]  = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001};
    vecs[8]  = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vecs[9]  = '{1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000};
    vecs[10] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000};
    vecs[11] = '{1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 4'b0000};
    vecs[12] = '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[13] = '{1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[14] = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 4'b0000};
    vecs[15] = '{1'b1, 32'h3F800000, 32'h33000000, 32'h3F800000, 4'b0001};
    vecs[16] = '{1'b0, 32'h3F800000, 32'hC0000000, 32'hBF800000, 4'b0000};
    vecs[17] = '{1'b0, 32'h4B800000, 32'h3FC00000, 32'h4B800001, 4'b0001};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset result", 64'(result), 64'd0);
    checkOutput("reset out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset out_flags", 64'(out_flags), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 18; i++)
      checkOutput($sformatf("model pin %0d", i), 64'(refModel(vecs[i].o, vecs[i].a, vecs[i].b)),
                  64'({vecs[i].fl, vecs[i].res}));

    @(posedge clk);
    #1;
    applyStimulus(vecs[0].o, vecs[0].a, vecs[0].b, 4'hA);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("latency cycle %0d", k + 1), 64'(out_valid), 64'(k == 3));
    end
    drain();

    for (int i = 0; i < 18; i++)
      applyStimulus(vecs[i].o, vecs[i].a, vecs[i].b, TAG_W'(i));
    drain();

    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus(i[0], 32'h3F800000 + (i << 20), 32'h40A00000, TAG_W'(i));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall out_valid", 64'(out_valid), 64'd1);
        checkOutput("stall in_ready", 64'(in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 4; i++)
      applyStimulus(vecs[i].o, vecs[i].a, vecs[i].b, TAG_W'(i + 8));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("post-reset in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(vecs[7].o, vecs[7].a, vecs[7].b, 4'h5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/fp_add_sub_pipe.md
Name: fp_add_sub_pipe

Overview:
- Fully pipelined IEEE-754-style floating-point adder/subtractor with a per-transaction op select and valid/ready flow control.
- Exponent and mantissa widths are parameters. Default is binary32.
- Sits between the custom-instruction datapath and result writeback.
- Takes over the fixed-width, single-register, sign-steered add/sub units. Sign handling, subtract mode and special values are handled internally.

Parameters:
- EXP_W, 8, exponent field width (bits).
- MAN_W, 23, stored mantissa field width (bits), hidden bit excluded.
- TAG_W, 4, width of the opaque tag carried alongside each operation.
- Derived: W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts operands this cycle.
- op  in  1  0 = dataa+datab, 1 = dataa-datab.
- dataa  in  W  operand A.
- datab  in  W  operand B.
- in_tag  in  TAG_W  opaque tag, returned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  W  sum/difference.
- out_tag  out  TAG_W  tag of this result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset: all stage valid bits 0. out_valid=0, result=0, out_tag=0, out_flags=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation discards every in-flight operation. No result emerges.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline has 4 register stages; latency is exactly 4 cycles from accept to out_valid with no stall.
  - S1 unpack/swap: effective B sign = datab sign XOR op. Order operands so |X| >= |Y|. Compute exponent difference. Classify zero/inf/NaN/denormal.
  - S2 align: right-shift Y significand by the difference, saturating at MAN_W+3. Keep guard, round and sticky bits (sticky = OR of all shifted-out bits).
  - S3 add/sub: add significands when effective signs are equal, otherwise subtract. Result sign = sign of X.
  - S4 normalise/round: leading-zero count and left shift, or 1-bit right shift on carry-out. Round to nearest, ties to even. Re-normalise if rounding carries. Pack.
- Stall: in_ready = !out_valid || out_ready.
  - When in_ready=0, every stage holds and bubbles are not collapsed.
  - Throughput is 1 per cycle while out_ready=1.
- Denormal inputs are flushed to signed zero and do not raise flags.
- Results below the minimum normal become signed zero with underflow=1 and inexact=1.
- Special cases, resolved in S1 and carried through:
  - Either operand NaN gives canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0). invalid=0 unless it is inf-inf.
  - +inf + -inf (effective) gives canonical qNaN with invalid=1.
  - inf with a finite operand gives that inf.
  - Exact cancellation (X == -Y, finite) gives +0.
  - (+0)+(+0) = +0; (-0)+(-0) = -0; (+0)+(-0) = +0.
- Overflow: rounded exponent >= 2^EXP_W-1 gives signed inf, overflow=1, inexact=1.
- inexact = 1 whenever any nonzero guard/round/sticky bit was discarded.
- out_tag is the in_tag of the same operation. Ordering is strictly FIFO.

Test Plan (default parameters):
- op=0, dataa=0x3F800000, datab=0x40000000, out_ready=1 -> 4 cycles later: result=0x40400000, flags=0000.
- op=1, dataa=0x40400000, datab=0x3F800000 -> result=0x40000000. Same values with op=0 and datab=0xBF800000 -> result=0x40000000.
- op=1, dataa=datab=0x3F800000 -> result=0x00000000.
- Special values:
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000 with invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000 with overflow=1 and inexact=1.
- 0x3F800000 + 0x33800000 (2^-24, a tie) -> 0x3F800000 with inexact=1. 0x3F800001 + 0x33800000 -> 0x3F800002.
- Stream of 8 ops with tags 0..7, holding out_ready=0 for 3 cycles mid-stream:
  - in_ready drops while out_valid=1 and out_ready=0.
  - No result is lost or duplicated; out_tag sequence is 0..7.
  - Assert reset for one cycle mid-stream -> out_valid=0 the next cycle and no stale results afterwards.
